// File: rtl/beam_scanner_pkg.sv
// Shared register map, bit positions and event-word layout for the beam event scanner.
package beam_scanner_pkg;

   // Register addresses on the Avalon-MM slave
   localparam logic [1:0] ADDR_EVENT    = 2'd0;
   localparam logic [1:0] ADDR_STATUS   = 2'd1;
   localparam logic [1:0] ADDR_CONTROL  = 2'd2;
   localparam logic [1:0] ADDR_RESERVED = 2'd3;

   // Status word layout
   localparam int ST_OVERFLOW_BIT = 31;
   localparam int ST_COUNT_LSB    = 16;
   localparam int ST_COUNT_W      = 8;
   localparam int ST_BROKEN_LSB   = 0;
   localparam int ST_BROKEN_W     = 16;

   // Control word layout
   localparam int CTL_IRQ_EN_BIT  = 31;
   localparam int CTL_MASK_W      = 16;

   // Event word: [31] valid, [16] pedal, [8] type, [3:0] channel
   typedef struct packed {
      logic        valid;
      logic [13:0] rsv_hi;
      logic        pedal;
      logic [6:0]  rsv_mid;
      logic        note_on;
      logic [3:0]  rsv_lo;
      logic [3:0]  chan;
   } event_word_t;

   // Build an event word with all reserved bits held at zero
   function automatic event_word_t make_event(input logic pedal, input logic note_on,
                                              input logic [3:0] chan);
      event_word_t w;
      w         = '0;
      w.valid   = 1'b1;
      w.pedal   = pedal;
      w.note_on = note_on;
      w.chan    = chan;
      return w;
   endfunction

endpackage

// File: rtl/beam_debounce.sv
// One photodiode channel: 2-FF synchroniser, stability counter, debounced level
// and a one-cycle change pulse aligned with the debounced level update.
module beam_debounce #(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic IDLE_LEVEL      = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic change
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Bring the asynchronous level into the clock domain
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= IDLE_LEVEL;
         sync2 <= IDLE_LEVEL;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         level  <= IDLE_LEVEL;
         change <= 1'b0;
      end else begin
         change <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level  <= sync2;
            cnt    <= '0;
            change <= 1'b1;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/beam_event_scanner.sv
// Scans debounced photodiode channels, queues note-on/off events in a FIFO and
// exposes them over a small Avalon-MM register file with a level interrupt.
//
// Bus handshake: avs_read and avs_write are single-cycle strobes with no wait
// states; a read is accepted on the edge where avs_read is high and its data is
// presented on avs_readdata from that edge on, held until the next read.
module beam_event_scanner
   import beam_scanner_pkg::*;
#(
   parameter int   NUM_BEAMS       = 8,
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter int   FIFO_DEPTH      = 16,
   parameter logic BROKEN_LEVEL    = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_BEAMS-1:0] photodiodes,
   input  logic                 pedal,
   input  logic [1:0]           avs_address,
   input  logic                 avs_read,
   input  logic                 avs_write,
   input  logic [31:0]          avs_writedata,
   output logic [31:0]          avs_readdata,
   output logic                 irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [NUM_BEAMS-1:0] level;
   logic [NUM_BEAMS-1:0] change;
   logic [NUM_BEAMS-1:0] broken;
   logic [NUM_BEAMS-1:0] pending;
   logic [NUM_BEAMS-1:0] chan_type;
   logic [NUM_BEAMS-1:0] mask;
   logic [NUM_BEAMS-1:0] mask_d;
   logic [NUM_BEAMS-1:0] push_onehot;
   logic [3:0]           push_chan;
   logic                 irq_en;
   logic                 pedal_s1;
   logic                 pedal_s2;

   logic [31:0]          mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CW-1:0]        count;
   logic                 overflow;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 push;
   logic                 pop;
   logic                 push_ok;
   logic                 drop;
   logic                 ctl_write;
   logic                 status_write;
   event_word_t          push_word;
   logic [31:0]          status_word;
   logic [31:0]          control_word;
   logic                 unused_wdata;

   for (genvar g = 0; g < NUM_BEAMS; g++) begin : g_beam
      beam_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .IDLE_LEVEL     (~BROKEN_LEVEL)
      ) u_debounce (
         .clk   (clk),
         .reset (reset),
         .raw   (photodiodes[g]),
         .level (level[g]),
         .change(change[g])
      );
   end

   assign broken = ~(level ^ {NUM_BEAMS{BROKEN_LEVEL}});

   // Synchronise the sustain pedal before it is sampled into event words
   always_ff @(posedge clk) begin
      if (reset) begin
         pedal_s1 <= 1'b0;
         pedal_s2 <= 1'b0;
      end else begin
         pedal_s1 <= pedal;
         pedal_s2 <= pedal_s1;
      end
   end

   assign ctl_write    = avs_write && (avs_address == ADDR_CONTROL);
   assign status_write = avs_write && (avs_address == ADDR_STATUS);
   // A mask write takes effect on pending flags in the same cycle it lands
   assign mask_d       = ctl_write ? avs_writedata[NUM_BEAMS-1:0] : mask;

   // Lowest-index pending channel wins the single push slot
   assign push_onehot = pending & (~pending + NUM_BEAMS'(1));
   assign push        = |pending;

   // Encode the winning channel index
   always_comb begin
      push_chan = '0;
      for (int i = 0; i < NUM_BEAMS; i++) begin
         if (push_onehot[i]) push_chan = 4'(i);
      end
   end

   assign push_word  = make_event(pedal_s2, |(chan_type & push_onehot), push_chan);
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CW'(FIFO_DEPTH));
   assign pop        = avs_read && (avs_address == ADDR_EVENT) && !fifo_empty;
   assign push_ok    = push && (!fifo_full || pop);
   assign drop       = push && fifo_full && !pop;

   // Control register: irq enable and per-channel enable mask
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_en <= 1'b0;
         mask   <= '1;
      end else if (ctl_write) begin
         irq_en <= avs_writedata[CTL_IRQ_EN_BIT];
         mask   <= mask_d;
      end
   end

   // Pending flags: set by enabled changes, cleared by push or by masking
   always_ff @(posedge clk) begin
      if (reset) begin
         pending   <= '0;
         chan_type <= '0;
      end else begin
         pending   <= ((pending & ~push_onehot) | change) & mask_d;
         chan_type <= (chan_type & ~change) | (broken & change);
      end
   end

   // Event storage; pointers alone define occupancy so no reset is needed here
   always_ff @(posedge clk) begin
      if (!reset && push_ok) mem[wr_ptr] <= push_word;
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (drop)                                           overflow <= 1'b1;
         else if (status_write && avs_writedata[ST_OVERFLOW_BIT]) overflow <= 1'b0;
      end
   end

   // Assemble the status and control read words
   always_comb begin
      status_word                                 = '0;
      status_word[ST_OVERFLOW_BIT]                = overflow;
      status_word[ST_COUNT_LSB +: ST_COUNT_W]     = ST_COUNT_W'(count);
      status_word[ST_BROKEN_LSB +: ST_BROKEN_W]   = ST_BROKEN_W'(broken);
      control_word                                = '0;
      control_word[CTL_IRQ_EN_BIT]                = irq_en;
      control_word[CTL_MASK_W-1:0]                = CTL_MASK_W'(mask);
   end

   // Registered read port; holds its value between reads
   always_ff @(posedge clk) begin
      if (reset) begin
         avs_readdata <= '0;
      end else if (avs_read) begin
         case (avs_address)
            ADDR_EVENT:    avs_readdata <= fifo_empty ? 32'h0 : mem[rd_ptr];
            ADDR_STATUS:   avs_readdata <= status_word;
            ADDR_CONTROL:  avs_readdata <= control_word;
            ADDR_RESERVED: avs_readdata <= 32'h0;
            default:       avs_readdata <= 32'h0;
         endcase
      end
   end

   // Level interrupt while events or an overflow are outstanding
   always_ff @(posedge clk) begin
      if (reset) irq <= 1'b0;
      else       irq <= irq_en && (!fifo_empty || overflow);
   end

   assign unused_wdata = ^avs_writedata;

endmodule

// File: tb/tb_beam_event_scanner.sv
// Self-checking bench for beam_event_scanner: register table, directed
// multi-cycle sequences and randomized beam activity against a reference model.
module tb_beam_event_scanner;

   localparam int NB = 8;
   localparam int DB = 4;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [NB-1:0] photodiodes;
   logic          pedal;
   logic [1:0]    avs_address;
   logic          avs_read;
   logic          avs_write;
   logic [31:0]   avs_writedata;
   logic [31:0]   avs_readdata;
   logic          irq;

   int            checks   = 0;
   int            failures = 0;
   logic [31:0]   exp_q[$];
   logic [NB-1:0] model_broken;
   logic [NB-1:0] model_mask;

   typedef struct {
      bit          wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } reg_vec_t;

   reg_vec_t vecs[14];

   // Clock
   always #5 clk = ~clk;

   beam_event_scanner #(
      .NUM_BEAMS      (NB),
      .DEBOUNCE_CYCLES(DB),
      .FIFO_DEPTH     (FD),
      .BROKEN_LEVEL   (1'b0)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .photodiodes  (photodiodes),
      .pedal        (pedal),
      .avs_address  (avs_address),
      .avs_read     (avs_read),
      .avs_write    (avs_write),
      .avs_writedata(avs_writedata),
      .avs_readdata (avs_readdata),
      .irq          (irq)
   );

   // Advance n clock edges and settle 1 ns past the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      tick(1);
      avs_write     = 1'b0;
   endtask

   task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
      avs_address = a;
      avs_read    = 1'b1;
      tick(1);
      avs_read    = 1'b0;
      d           = avs_readdata;
   endtask

   task automatic expect_read(input string name, input logic [1:0] a, input logic [31:0] e);
      logic [31:0] d;
      reg_read(a, d);
      check(name, d, e);
   endtask

   task automatic check_irq(input string name, input logic e);
      check(name, {31'b0, irq}, {31'b0, e});
   endtask

   // Pop every expected event, then confirm the FIFO reads back empty
   task automatic drain(input string name);
      logic [31:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         expect_read(name, 2'd0, e);
      end
      expect_read({name, " empty"}, 2'd0, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got still running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      photodiodes   = '1;
      pedal         = 1'b0;
      avs_address   = 2'd0;
      avs_read      = 1'b0;
      avs_write     = 1'b0;
      avs_writedata = 32'h0;
      reset         = 1'b1;
      tick(3);
      check_irq("reset irq", 1'b0);
      check("reset readdata", avs_readdata, 32'h0);
      reset = 1'b0;
      tick(1);

      // Register map table
      vecs[0]  = '{1'b0, 2'd1, 32'h0,        32'h0000_0000};
      vecs[1]  = '{1'b0, 2'd2, 32'h0,        32'h0000_00FF};
      vecs[2]  = '{1'b0, 2'd0, 32'h0,        32'h0000_0000};
      vecs[3]  = '{1'b0, 2'd3, 32'h0,        32'h0000_0000};
      vecs[4]  = '{1'b1, 2'd2, 32'h8000_00A5, 32'h0};
      vecs[5]  = '{1'b0, 2'd2, 32'h0,        32'h8000_00A5};
      vecs[6]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
      vecs[7]  = '{1'b0, 2'd3, 32'h0,        32'h0000_0000};
      vecs[8]  = '{1'b1, 2'd0, 32'h1234_5678, 32'h0};
      vecs[9]  = '{1'b0, 2'd0, 32'h0,        32'h0000_0000};
      vecs[10] = '{1'b1, 2'd2, 32'h0001_FF3C, 32'h0};
      vecs[11] = '{1'b0, 2'd2, 32'h0,        32'h0000_003C};
      vecs[12] = '{1'b1, 2'd2, 32'h0000_00FF, 32'h0};
      vecs[13] = '{1'b0, 2'd2, 32'h0,        32'h0000_00FF};
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].wr) reg_write(vecs[i].addr, vecs[i].wdata);
         else            expect_read($sformatf("reg vec %0d", i), vecs[i].addr, vecs[i].exp);
      end

      // Beam 3 break with pedal down, then restore with pedal up
      pedal = 1'b1;
      tick(1);
      photodiodes[3] = 1'b0;
      tick(10);
      expect_read("beam3 break", 2'd0, 32'h8001_0103);
      expect_read("beam3 empty", 2'd0, 32'h0);
      pedal = 1'b0;
      photodiodes[3] = 1'b1;
      tick(12);
      expect_read("beam3 restore", 2'd0, 32'h8000_0003);
      expect_read("beam3 restore empty", 2'd0, 32'h0);

      // Glitch shorter than the debounce window
      photodiodes[5] = 1'b0;
      tick(3);
      photodiodes[5] = 1'b1;
      tick(12);
      expect_read("glitch status", 2'd1, 32'h0);
      expect_read("glitch fifo", 2'd0, 32'h0);

      // Simultaneous breaks come out lowest channel first
      photodiodes[1] = 1'b0;
      photodiodes[6] = 1'b0;
      tick(12);
      expect_read("dual status", 2'd1, 32'h0002_0042);
      expect_read("dual first", 2'd0, 32'h8000_0101);
      expect_read("dual second", 2'd0, 32'h8000_0106);
      expect_read("dual empty", 2'd0, 32'h0);
      photodiodes[1] = 1'b1;
      photodiodes[6] = 1'b1;
      tick(12);
      expect_read("dual off first", 2'd0, 32'h8000_0001);
      expect_read("dual off second", 2'd0, 32'h8000_0006);

      // Six events into a four-deep FIFO
      photodiodes[2:0] = 3'b000;
      tick(12);
      photodiodes[2:0] = 3'b111;
      tick(12);
      expect_read("ovf status", 2'd1, 32'h8004_0000);
      expect_read("ovf ev0", 2'd0, 32'h8000_0100);
      expect_read("ovf ev1", 2'd0, 32'h8000_0101);
      expect_read("ovf ev2", 2'd0, 32'h8000_0102);
      expect_read("ovf ev3", 2'd0, 32'h8000_0000);
      expect_read("ovf empty", 2'd0, 32'h0);
      expect_read("ovf sticky", 2'd1, 32'h8000_0000);
      reg_write(2'd1, 32'h8000_0000);
      expect_read("ovf cleared", 2'd1, 32'h0);

      // Interrupt and masking
      reg_write(2'd2, 32'h8000_00FF);
      check_irq("irq idle", 1'b0);
      photodiodes[0] = 1'b0;
      tick(12);
      check_irq("irq raised", 1'b1);
      expect_read("irq event", 2'd0, 32'h8000_0100);
      tick(2);
      check_irq("irq dropped", 1'b0);
      reg_write(2'd2, 32'h8000_00FE);
      photodiodes[0] = 1'b1;
      tick(12);
      expect_read("masked restore fifo", 2'd0, 32'h0);
      check_irq("masked irq", 1'b0);
      expect_read("masked restore status", 2'd1, 32'h0);
      photodiodes[0] = 1'b0;
      tick(12);
      expect_read("masked break status", 2'd1, 32'h0000_0001);
      expect_read("masked break fifo", 2'd0, 32'h0);
      photodiodes[0] = 1'b1;
      tick(12);
      reg_write(2'd2, 32'h8000_00FF);

      // Reset with three events queued
      photodiodes[4:2] = 3'b000;
      tick(12);
      check_irq("pre-reset irq", 1'b1);
      expect_read("pre-reset status", 2'd1, 32'h0003_001C);
      photodiodes[4:2] = 3'b111;
      reset = 1'b1;
      tick(1);
      check_irq("post-reset irq", 1'b0);
      reset = 1'b0;
      expect_read("post-reset status", 2'd1, 32'h0);
      expect_read("post-reset mask", 2'd2, 32'h0000_00FF);
      expect_read("post-reset fifo", 2'd0, 32'h0);
      tick(12);
      expect_read("post-reset quiet", 2'd0, 32'h0);

      // Randomized single-channel activity against the reference model
      model_broken = '0;
      model_mask   = 8'($urandom_range(0, 255));
      reg_write(2'd2, {24'b0, model_mask});
      for (int step = 0; step < 30; step++) begin
         int          ch;
         int          kind;
         int          g;
         logic        pl;
         logic [31:0] e;
         ch    = $urandom_range(0, NB - 1);
         kind  = $urandom_range(0, 2);
         pl    = 1'($urandom_range(0, 1));
         pedal = pl;
         tick(3);
         if (kind == 0) begin
            g = $urandom_range(1, DB - 1);
            photodiodes[ch] = ~photodiodes[ch];
            tick(g);
            photodiodes[ch] = ~photodiodes[ch];
            tick(12);
         end else begin
            photodiodes[ch] = ~photodiodes[ch];
            tick(12);
            model_broken[ch] = (photodiodes[ch] == 1'b0);
            if (model_mask[ch]) begin
               e       = 32'h8000_0000;
               e[16]   = pl;
               e[8]    = model_broken[ch];
               e[3:0]  = 4'(ch);
               exp_q.push_back(e);
            end
         end
         if (step % 3 == 2) begin
            drain($sformatf("rand step %0d", step));
            expect_read($sformatf("rand status %0d", step), 2'd1, {24'b0, model_broken});
            model_mask = 8'($urandom_range(0, 255));
            reg_write(2'd2, {24'b0, model_mask});
         end
      end
      drain("rand final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/beam_event_scanner.md
BEAM_EVENT_SCANNER -- requirements
Module: beam_event_scanner

Interface
REQ-001 Parameter NUM_BEAMS, default 8, number of photodiode channels (legal 1..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles before a level change is accepted (legal >= NUM_BEAMS+2).
REQ-003 Parameter FIFO_DEPTH, default 16, event FIFO entries (power of two, 2..128).
REQ-004 Parameter BROKEN_LEVEL, default 0, input level meaning "beam broken".
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset  in  1  reset; synchronous, active-high.
REQ-007 photodiodes  in  NUM_BEAMS  raw asynchronous photodiode levels.
REQ-008 pedal  in  1  raw asynchronous sustain pedal level.
REQ-009 avs_address  in  2  register select.
REQ-010 avs_read / avs_write  in  1 each  Avalon-MM strobes.
REQ-011 avs_writedata  in  32 / avs_readdata  out  32  register data.
REQ-012 irq  out  1  level interrupt.

Function
REQ-013 Every photodiode and pedal input SHALL pass a 2-FF synchroniser before use.
REQ-014 Per channel, debounced state SHALL change only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; counter clears whenever input equals debounced state.
REQ-015 A debounced change SHALL set that channel's pending flag and latch its type (1 = broken/note-on, 0 = restored/note-off), only if the channel's enable-mask bit is 1.
REQ-016 Each cycle the lowest-index pending channel SHALL be pushed to the FIFO and its pending flag cleared; one push per cycle max.
REQ-017 Event word: [31] valid=1, [16] synchronised pedal at push cycle, [8] type, [3:0] channel index, other bits 0.
REQ-018 Push when FIFO full and no same-cycle pop: event dropped, pending cleared, sticky overflow set; push and pop in same cycle while full SHALL both succeed, no overflow.
REQ-019 Read latency SHALL be 1 cycle; avs_readdata holds last value between reads.
REQ-020 Address 0 read: head event word and pop; FIFO empty returns 0x00000000, no pop.
REQ-021 Address 1 read: [31] overflow, [23:16] FIFO count, [15:0] debounced broken states (unused bits 0); write with bit 31 = 1 clears overflow.
REQ-022 Address 2 read/write: [31] irq enable, [15:0] enable mask (bits >= NUM_BEAMS read 0).
REQ-023 Address 3 reads 0; writes ignored; writes to address 0 ignored.
REQ-024 irq SHALL equal irq_enable AND (FIFO not empty OR overflow), registered.
REQ-025 Clearing a mask bit SHALL clear that channel's pending flag; debouncing continues.

Reset
REQ-026 On reset: FIFO empty, count 0, overflow 0, pending 0, debounce counters 0, debounced states "not broken", synchronisers at not-broken level, irq enable 0, mask all ones, irq 0, avs_readdata 0.
REQ-027 Reset asserted mid-operation SHALL discard all queued and pending events in the same cycle.

Structure
REQ-028 Package beam_scanner_pkg SHALL hold register address constants, event-word and status bit positions, and event-word type.
REQ-029 Sub-module beam_debounce (synchroniser + counter + debounced state + change pulse) SHALL be instantiated NUM_BEAMS times via generate; FIFO inline.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, NUM_BEAMS=8, BROKEN_LEVEL=0)
REQ-030 Beam 3 low 10 cycles, pedal high -> one event 0x80010103 at address 0; next read 0x00000000.
REQ-031 Beam 5 low 3 cycles then high -> no event, status [15:0]=0x0000.
REQ-032 Beams 1 and 6 low same cycle -> events 0x80000101 then 0x80000106 in that order.
REQ-033 Six events with no reads -> count 4, status bit 31=1, first four events retained; write 0x80000000 to address 1 -> bit 31=0.
REQ-034 Write 0x800000FF to address 2, break beam 0 -> irq rises; read address 0 once -> irq falls within 2 cycles; mask 0xFE -> beam 0 changes produce no events.
REQ-035 Reset pulse with 3 queued events -> count 0, irq 0, mask reads 0x000000FF.
